ex_mem_wb_forwarding: RTL and testbench

Back end of the execute-stage operand interface: holds the EX/MEM and MEM/WB pipeline registers and drives everything the execute stage consumes from downstream. That is `forwardA`/`forwardB`, `ex_mem_alu_result` and `wb_data`, plus the load-use stall and the branch flush/redirect. It sits between `execute` and the data memory / register-file write port in the 5-stage RV32I pipeline.

---
 rtl/ex_mem_wb_forwarding_pkg.sv | 13 +
 rtl/ex_mem_wb_forwarding_forward_sel.sv | 29 ++
 rtl/ex_mem_wb_forwarding.sv | 163 ++++++++++++++++
 tb/tb_ex_mem_wb_forwarding.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/ex_mem_wb_forwarding_pkg.sv
// Shared constants for the EX/MEM/WB back end: operand-forward select codes
// and the hard-wired zero register index.
package ex_mem_wb_forwarding_pkg;

  localparam logic [1:0] FWD_RF     = 2'b00;
  localparam logic [1:0] FWD_MEM_WB = 2'b01;
  localparam logic [1:0] FWD_EX_MEM = 2'b10;

  localparam logic [4:0] REG_X0 = 5'd0;

  localparam int unsigned REG_W = 5;

endpackage

// File: rtl/ex_mem_wb_forwarding_forward_sel.sv
// Per-operand forwarding select; the younger EX/MEM writer wins over MEM/WB,
// and x0 is never forwarded.
module forward_sel
  import ex_mem_wb_forwarding_pkg::*;
(
  input  logic [REG_W-1:0] src_i,
  input  logic [REG_W-1:0] ex_mem_rd_i,
  input  logic             ex_mem_regwrite_i,
  input  logic [REG_W-1:0] mem_wb_rd_i,
  input  logic             mem_wb_regwrite_i,
  output logic [1:0]       fwd_o
);

  logic ex_mem_hit;
  logic mem_wb_hit;

  assign ex_mem_hit = ex_mem_regwrite_i && (ex_mem_rd_i != REG_X0) && (ex_mem_rd_i == src_i);
  assign mem_wb_hit = mem_wb_regwrite_i && (mem_wb_rd_i != REG_X0) && (mem_wb_rd_i == src_i);

  always_comb begin
    fwd_o = FWD_RF;
    if (ex_mem_hit) begin
      fwd_o = FWD_EX_MEM;
    end else if (mem_wb_hit) begin
      fwd_o = FWD_MEM_WB;
    end
  end

endmodule

// File: rtl/ex_mem_wb_forwarding.sv
// EX/MEM and MEM/WB pipeline registers plus everything execute consumes from
// downstream: forward selects, load-use stall, branch flush/redirect, counters.
module ex_mem_wb_forwarding
  import ex_mem_wb_forwarding_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [XLEN-1:0]  ex_alu_result,
  input  logic [XLEN-1:0]  ex_rs2_data,
  input  logic [4:0]       ex_rd,
  input  logic             ex_regwrite,
  input  logic             ex_memread,
  input  logic             ex_memwrite,
  input  logic             ex_memtoreg,
  input  logic             ex_branch_taken,
  input  logic [XLEN-1:0]  ex_branch_target,
  input  logic [4:0]       id_ex_rs1,
  input  logic [4:0]       id_ex_rs2,
  input  logic [4:0]       if_id_rs1,
  input  logic [4:0]       if_id_rs2,
  input  logic             if_id_use_rs1,
  input  logic             if_id_use_rs2,
  input  logic [4:0]       id_ex_rd,
  input  logic             id_ex_memread,
  input  logic [XLEN-1:0]  dmem_rdata,
  output logic [1:0]       forwardA,
  output logic [1:0]       forwardB,
  output logic [XLEN-1:0]  ex_mem_alu_result,
  output logic [XLEN-1:0]  dmem_addr,
  output logic [XLEN-1:0]  dmem_wdata,
  output logic             dmem_we,
  output logic             dmem_re,
  output logic [XLEN-1:0]  wb_data,
  output logic [4:0]       wb_rd,
  output logic             wb_regwrite,
  output logic             stall,
  output logic             flush_if_id,
  output logic             flush_id_ex,
  output logic             redirect_valid,
  output logic [XLEN-1:0]  redirect_pc,
  output logic [31:0]      stall_count,
  output logic [31:0]      flush_count
);

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  // EX -> EX/MEM
  logic [XLEN-1:0] exm_alu_q, exm_rs2_q;
  logic [4:0]      exm_rd_q;
  logic            exm_regwrite_q, exm_memread_q, exm_memwrite_q, exm_memtoreg_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exm_alu_q      <= '0;
      exm_rs2_q      <= '0;
      exm_rd_q       <= '0;
      exm_regwrite_q <= 1'b0;
      exm_memread_q  <= 1'b0;
      exm_memwrite_q <= 1'b0;
      exm_memtoreg_q <= 1'b0;
    end else begin
      exm_alu_q      <= ex_alu_result;
      exm_rs2_q      <= ex_rs2_data;
      exm_rd_q       <= ex_rd;
      exm_regwrite_q <= ex_regwrite;
      exm_memread_q  <= ex_memread;
      exm_memwrite_q <= ex_memwrite;
      exm_memtoreg_q <= ex_memtoreg;
    end
  end

  // EX/MEM -> MEM/WB
  logic [XLEN-1:0] mwb_alu_q, mwb_rdata_q;
  logic [4:0]      mwb_rd_q;
  logic            mwb_regwrite_q, mwb_memtoreg_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mwb_alu_q      <= '0;
      mwb_rdata_q    <= '0;
      mwb_rd_q       <= '0;
      mwb_regwrite_q <= 1'b0;
      mwb_memtoreg_q <= 1'b0;
    end else begin
      mwb_alu_q      <= exm_alu_q;
      mwb_rdata_q    <= dmem_rdata;
      mwb_rd_q       <= exm_rd_q;
      mwb_regwrite_q <= exm_regwrite_q;
      mwb_memtoreg_q <= exm_memtoreg_q;
    end
  end

  assign ex_mem_alu_result = exm_alu_q;
  assign dmem_addr         = exm_alu_q;
  assign dmem_wdata        = exm_rs2_q;
  assign dmem_we           = exm_memwrite_q;
  assign dmem_re           = exm_memread_q;
  assign wb_data           = mwb_memtoreg_q ? mwb_rdata_q : mwb_alu_q;
  assign wb_rd             = mwb_rd_q;
  assign wb_regwrite       = mwb_regwrite_q;

  forward_sel u_fwd_a (
    .src_i             (id_ex_rs1),
    .ex_mem_rd_i       (exm_rd_q),
    .ex_mem_regwrite_i (exm_regwrite_q),
    .mem_wb_rd_i       (mwb_rd_q),
    .mem_wb_regwrite_i (mwb_regwrite_q),
    .fwd_o             (forwardA)
  );

  forward_sel u_fwd_b (
    .src_i             (id_ex_rs2),
    .ex_mem_rd_i       (exm_rd_q),
    .ex_mem_regwrite_i (exm_regwrite_q),
    .mem_wb_rd_i       (mwb_rd_q),
    .mem_wb_regwrite_i (mwb_regwrite_q),
    .fwd_o             (forwardB)
  );

  // Hazard and redirect controls; held low while reset is asserted.
  logic hz;
  logic br;

  assign hz = id_ex_memread && (id_ex_rd != REG_X0) &&
              ((if_id_use_rs1 && (if_id_rs1 == id_ex_rd)) ||
               (if_id_use_rs2 && (if_id_rs2 == id_ex_rd)));
  assign br = rst_n && ex_branch_taken;

  assign stall          = rst_n && hz && !ex_branch_taken;
  assign flush_id_ex    = rst_n && (hz || ex_branch_taken);
  assign flush_if_id    = br;
  assign redirect_valid = br;
  assign redirect_pc    = br ? ex_branch_target : '0;

  // Performance counters
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall)          stall_cnt_d = sat_inc(stall_cnt_q);
    if (redirect_valid) flush_cnt_d = sat_inc(flush_cnt_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_count = stall_cnt_q;
  assign flush_count = flush_cnt_q;

endmodule

// File: tb/tb_ex_mem_wb_forwarding.sv
// Directed bench for ex_mem_wb_forwarding: expected values are queued as each
// step is driven and popped against the DUT outputs once they are valid.
module tb_ex_mem_wb_forwarding;

  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [XLEN-1:0] ex_alu_result, ex_rs2_data, ex_branch_target, dmem_rdata;
  logic [4:0]      ex_rd, id_ex_rs1, id_ex_rs2, if_id_rs1, if_id_rs2, id_ex_rd;
  logic            ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg, ex_branch_taken;
  logic            if_id_use_rs1, if_id_use_rs2, id_ex_memread;
  logic [1:0]      forwardA, forwardB;
  logic [XLEN-1:0] ex_mem_alu_result, dmem_addr, dmem_wdata, wb_data, redirect_pc;
  logic            dmem_we, dmem_re, wb_regwrite, stall, flush_if_id, flush_id_ex, redirect_valid;
  logic [4:0]      wb_rd;
  logic [31:0]     stall_count, flush_count;

  always #5 clk = ~clk;

  ex_mem_wb_forwarding #(.XLEN(XLEN)) dut (
    .clk(clk), .rst_n(rst_n),
    .ex_alu_result(ex_alu_result), .ex_rs2_data(ex_rs2_data), .ex_rd(ex_rd),
    .ex_regwrite(ex_regwrite), .ex_memread(ex_memread), .ex_memwrite(ex_memwrite),
    .ex_memtoreg(ex_memtoreg), .ex_branch_taken(ex_branch_taken),
    .ex_branch_target(ex_branch_target), .id_ex_rs1(id_ex_rs1), .id_ex_rs2(id_ex_rs2),
    .if_id_rs1(if_id_rs1), .if_id_rs2(if_id_rs2), .if_id_use_rs1(if_id_use_rs1),
    .if_id_use_rs2(if_id_use_rs2), .id_ex_rd(id_ex_rd), .id_ex_memread(id_ex_memread),
    .dmem_rdata(dmem_rdata), .forwardA(forwardA), .forwardB(forwardB),
    .ex_mem_alu_result(ex_mem_alu_result), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_we(dmem_we), .dmem_re(dmem_re), .wb_data(wb_data), .wb_rd(wb_rd),
    .wb_regwrite(wb_regwrite), .stall(stall), .flush_if_id(flush_if_id),
    .flush_id_ex(flush_id_ex), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .stall_count(stall_count), .flush_count(flush_count)
  );

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t q[$];
  int   tests  = 0;
  int   failed = 0;

  task automatic expect_val(input string tag, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    q.push_back(e);
  endtask

  task automatic chk(input logic [31:0] obs);
    exp_t e;
    tests++;
    if (q.size() == 0) begin
      failed++;
      $error("FAIL scoreboard_underflow observed=%h expected=<queued value>", obs);
    end else begin
      e = q.pop_front();
      assert (obs === e.val) else begin
        failed++;
        $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_ex();
    ex_alu_result = '0; ex_rs2_data = '0; ex_rd = '0;
    ex_regwrite = 0; ex_memread = 0; ex_memwrite = 0; ex_memtoreg = 0;
    ex_branch_taken = 0; ex_branch_target = '0;
  endtask

  task automatic clear_all();
    clear_ex();
    id_ex_rs1 = '0; id_ex_rs2 = '0; if_id_rs1 = '0; if_id_rs2 = '0;
    if_id_use_rs1 = 0; if_id_use_rs2 = 0; id_ex_rd = '0; id_ex_memread = 0;
    dmem_rdata = '0;
  endtask

  initial begin
    // Reset with random inputs, including a taken branch and a load-use pattern.
    rst_n = 1'b0;
    ex_alu_result = $urandom; ex_rs2_data = $urandom; ex_rd = 5'd9;
    ex_regwrite = 1; ex_memread = 1; ex_memwrite = 1; ex_memtoreg = 1;
    ex_branch_taken = 1; ex_branch_target = $urandom | 32'h1;
    id_ex_rs1 = 5'd9; id_ex_rs2 = 5'd9; if_id_rs1 = 5'd6; if_id_rs2 = 5'd6;
    if_id_use_rs1 = 1; if_id_use_rs2 = 1; id_ex_rd = 5'd6; id_ex_memread = 1;
    dmem_rdata = $urandom;
    tick(); tick();
    expect_val("rst_forwardA", 0);     chk(forwardA);
    expect_val("rst_forwardB", 0);     chk(forwardB);
    expect_val("rst_exm_alu", 0);      chk(ex_mem_alu_result);
    expect_val("rst_wb_data", 0);      chk(wb_data);
    expect_val("rst_wb_rd", 0);        chk(wb_rd);
    expect_val("rst_wb_regwrite", 0);  chk(wb_regwrite);
    expect_val("rst_dmem_addr", 0);    chk(dmem_addr);
    expect_val("rst_dmem_wdata", 0);   chk(dmem_wdata);
    expect_val("rst_dmem_we", 0);      chk(dmem_we);
    expect_val("rst_dmem_re", 0);      chk(dmem_re);
    expect_val("rst_stall", 0);        chk(stall);
    expect_val("rst_flush_if_id", 0);  chk(flush_if_id);
    expect_val("rst_flush_id_ex", 0);  chk(flush_id_ex);
    expect_val("rst_redirect_v", 0);   chk(redirect_valid);
    expect_val("rst_redirect_pc", 0);  chk(redirect_pc);
    expect_val("rst_stall_count", 0);  chk(stall_count);
    expect_val("rst_flush_count", 0);  chk(flush_count);
    clear_all();
    rst_n = 1'b1;
    tick();

    // EX/MEM forward, then MEM/WB forward one cycle later.
    ex_rd = 5'd3; ex_regwrite = 1; ex_alu_result = 32'd42;
    tick();
    clear_ex();
    id_ex_rs1 = 5'd3;
    expect_val("exm_fwdA", 2'b10);  expect_val("exm_alu", 32'd42);
    #1;
    chk(forwardA); chk(ex_mem_alu_result);
    tick();
    expect_val("mwb_fwdA", 2'b01); expect_val("mwb_wb_data", 32'd42);
    expect_val("mwb_wb_rd", 32'd3); expect_val("mwb_wb_regwrite", 1);
    chk(forwardA); chk(wb_data); chk(wb_rd); chk(wb_regwrite);

    // Priority: older writer 9, younger writer 7, both to x5.
    clear_all();
    ex_rd = 5'd5; ex_regwrite = 1; ex_alu_result = 32'd9;
    tick();
    ex_rd = 5'd5; ex_regwrite = 1; ex_alu_result = 32'd7;
    tick();
    clear_ex();
    id_ex_rs2 = 5'd5;
    expect_val("prio_fwdB", 2'b10); expect_val("prio_exm_alu", 32'd7);
    expect_val("prio_wb_data", 32'd9);
    #1;
    chk(forwardB); chk(ex_mem_alu_result); chk(wb_data);

    // x0 is never forwarded; x5 now only matches MEM/WB.
    ex_rd = 5'd0; ex_regwrite = 1; ex_alu_result = 32'd55;
    tick();
    clear_ex();
    id_ex_rs1 = 5'd0; id_ex_rs2 = 5'd5;
    expect_val("x0_fwdA", 2'b00); expect_val("x0_fwdB_mwb", 2'b01);
    #1;
    chk(forwardA); chk(forwardB);

    // Load-use: one stall cycle, load data reaches write-back two cycles on.
    clear_all();
    tick(); tick();
    ex_rd = 5'd4; ex_regwrite = 1; ex_memread = 1; ex_memtoreg = 1; ex_alu_result = 32'h100;
    id_ex_memread = 1; id_ex_rd = 5'd4; if_id_rs2 = 5'd4; if_id_use_rs2 = 1;
    expect_val("lu_stall", 1); expect_val("lu_flush_id_ex", 1);
    expect_val("lu_flush_if_id", 0); expect_val("lu_redirect_v", 0);
    #1;
    chk(stall); chk(flush_id_ex); chk(flush_if_id); chk(redirect_valid);
    tick();
    clear_all();
    dmem_rdata = 32'h1234;
    expect_val("lu_bubble_stall", 0); expect_val("lu_dmem_re", 1);
    expect_val("lu_dmem_addr", 32'h100);
    #1;
    chk(stall); chk(dmem_re); chk(dmem_addr);
    tick();
    dmem_rdata = '0;
    id_ex_rs2 = 5'd4;
    expect_val("lu_wb_data", 32'h1234); expect_val("lu_wb_rd", 32'd4);
    expect_val("lu_stall_count", 1); expect_val("lu_consumer_fwdB", 2'b01);
    #1;
    chk(wb_data); chk(wb_rd); chk(stall_count); chk(forwardB);

    // Taken branch overrides a simultaneous load-use stall.
    clear_all();
    id_ex_memread = 1; id_ex_rd = 5'd8; if_id_rs1 = 5'd8; if_id_use_rs1 = 1;
    ex_branch_taken = 1; ex_branch_target = 32'd216;
    expect_val("br_stall", 0); expect_val("br_redirect_v", 1);
    expect_val("br_redirect_pc", 32'd216); expect_val("br_flush_if_id", 1);
    expect_val("br_flush_id_ex", 1);
    #1;
    chk(stall); chk(redirect_valid); chk(redirect_pc); chk(flush_if_id); chk(flush_id_ex);
    tick();
    clear_all();
    expect_val("br_flush_count", 1); expect_val("br_stall_count", 1);
    #1;
    chk(flush_count); chk(stall_count);

    // Store path.
    ex_memwrite = 1; ex_alu_result = 32'h40; ex_rs2_data = 32'hAB;
    tick();
    clear_ex();
    expect_val("st_dmem_we", 1); expect_val("st_dmem_addr", 32'h40);
    expect_val("st_dmem_wdata", 32'hAB); expect_val("st_dmem_re", 0);
    #1;
    chk(dmem_we); chk(dmem_addr); chk(dmem_wdata); chk(dmem_re);
    tick();
    expect_val("st_wb_regwrite", 0); expect_val("st_dmem_we_after", 0);
    chk(wb_regwrite); chk(dmem_we);

    // Mid-program reset discards in-flight state and clears counters.
    ex_rd = 5'd7; ex_regwrite = 1; ex_alu_result = 32'd77;
    tick();
    clear_ex();
    #2;
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    id_ex_rs1 = 5'd7;
    expect_val("mr_exm_alu", 0); expect_val("mr_fwdA", 2'b00);
    expect_val("mr_stall_count", 0); expect_val("mr_flush_count", 0);
    #1;
    chk(ex_mem_alu_result); chk(forwardA); chk(stall_count); chk(flush_count);

    tests++;
    assert (q.size() == 0) else begin
      failed++;
      $error("FAIL scoreboard_leftover observed=%0d expected=0", q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
